base64_pixel_unpacker: RTL and testbench

Parametrised next-generation base64 decoder for the UART-to-framebuffer path. It accepts base64 characters from the UART receiver and repacks the 6-bit sextets into pixels of configurable width, MSB first. Pixels pass through an internal FIFO to the memory controller. It adds padding/whitespace handling, invalid-character error flagging and frame-boundary tracking.

---
 rtl/base64_pixel_unpacker.sv | 168 ++++++++++++++++
 tb/tb_base64_pixel_unpacker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/base64_pixel_unpacker.sv
// rtl/base64_pixel_unpacker.sv - base64 character stream to PIXEL_W-bit pixel stream with output FIFO
// Tracks frame boundaries on both the push and pop sides of the FIFO.
module base64_pixel_unpacker #(
  parameter int PIXEL_W      = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_data_valid,
  output logic                               rx_data_ready,
  output logic [PIXEL_W-1:0]                 pixel_data,
  output logic                               pixel_valid,
  input  logic                               pixel_ready,
  output logic                               frame_done,
  output logic                               decode_error,
  input  logic                               err_clear,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int AW = PIXEL_W + 5;
  localparam int CW = $clog2(AW + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FRAME_PIXELS + 1);
  localparam logic [FW-1:0] LAST_PIX = FW'(FRAME_PIXELS - 1);
  localparam logic [CW-1:0] PW_CNT   = CW'(PIXEL_W);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]          state;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       acc_cnt;
  logic [FW-1:0]       push_cnt;
  logic [FW-1:0]       pop_cnt;

  logic [PIXEL_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [LW-1:0]       level;

  logic                is_sextet;
  logic                is_pad;
  logic                is_invalid;
  logic [5:0]          sextet;
  logic                accept;
  logic                full;
  logic                push;
  logic                pop;
  logic [CW-1:0]       cnt_add;
  logic [CW-1:0]       cnt_sub;
  logic [PIXEL_W-1:0]  push_pixel;

  // Character classification; whitespace falls through with no flag set.
  always_comb begin
    is_sextet  = 1'b0;
    is_pad     = 1'b0;
    is_invalid = 1'b0;
    sextet     = '0;
    if (rx_data >= 8'h41 && rx_data <= 8'h5A) begin
      is_sextet = 1'b1;
      sextet    = 6'(rx_data - 8'd65);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
      is_sextet = 1'b1;
      sextet    = 6'(rx_data - 8'd71);
    end else if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_sextet = 1'b1;
      sextet    = 6'(rx_data + 8'd4);
    end else if (rx_data == 8'h2B) begin
      is_sextet = 1'b1;
      sextet    = 6'd62;
    end else if (rx_data == 8'h2F) begin
      is_sextet = 1'b1;
      sextet    = 6'd63;
    end else if (rx_data == 8'h3D) begin
      is_pad = 1'b1;
    end else if (rx_data != 8'h0A && rx_data != 8'h0D && rx_data != 8'h20) begin
      is_invalid = 1'b1;
    end
  end

  assign rx_data_ready = rst_n && (state == S_FILL);
  assign accept        = rx_data_valid && rx_data_ready;
  assign full          = (level == LW'(FIFO_DEPTH));
  assign push          = (state == S_EMIT) && !full;
  assign pixel_valid   = (level != '0);
  assign pop           = pixel_valid && pixel_ready;
  assign cnt_add       = acc_cnt + CW'(6);
  assign cnt_sub       = acc_cnt - PW_CNT;
  // Valid bits sit right-aligned; shifting off the excess leaves the oldest PIXEL_W bits at the bottom.
  assign push_pixel    = PIXEL_W'(acc >> cnt_sub);
  assign pixel_data    = pixel_valid ? mem[rd_ptr] : '0;
  assign fifo_level    = level;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FILL;
      acc      <= '0;
      acc_cnt  <= '0;
      push_cnt <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept && is_sextet) begin
            acc     <= (acc << 6) | AW'(sextet);
            acc_cnt <= cnt_add;
            if (cnt_add >= PW_CNT) state <= S_EMIT;
          end else if (accept && is_pad) begin
            acc_cnt <= '0;
          end
        end
        default: begin
          if (push) begin
            if (push_cnt == LAST_PIX) begin
              push_cnt <= '0;
              acc_cnt  <= '0;
              state    <= S_FILL;
            end else begin
              push_cnt <= push_cnt + FW'(1);
              acc_cnt  <= cnt_sub;
              if (cnt_sub < PW_CNT) state <= S_FILL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decode_error <= 1'b0;
    end else if (accept && is_invalid) begin
      decode_error <= 1'b1;
    end else if (err_clear) begin
      decode_error <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pixel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && (pop_cnt == LAST_PIX);
      if (pop) pop_cnt <= (pop_cnt == LAST_PIX) ? '0 : pop_cnt + FW'(1);
    end
  end

endmodule

// File: tb/tb_base64_pixel_unpacker.sv
// tb/tb_base64_pixel_unpacker.sv - scoreboard bench for base64_pixel_unpacker
// Two instances: PIXEL_W=3/depth 4 and PIXEL_W=4/two-pixel frames.
module tb_base64_pixel_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r3_n, v3, rdy3, pv3, pr3, fd3, err3, clr3;
  logic [7:0] d3;
  logic [2:0] pd3;
  logic [2:0] lvl3;

  logic       r4_n, v4, rdy4, pv4, pr4, fd4, err4, clr4;
  logic [7:0] d4;
  logic [3:0] pd4;
  logic [3:0] lvl4;

  int checks = 0;
  int failures = 0;
  int q3[$];
  int q4[$];
  int pops4 = 0;
  int fd4_cnt = 0;
  bit fd_pend4 = 1'b0;

  base64_pixel_unpacker #(.PIXEL_W(3), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(r3_n), .rx_data(d3), .rx_data_valid(v3), .rx_data_ready(rdy3),
    .pixel_data(pd3), .pixel_valid(pv3), .pixel_ready(pr3), .frame_done(fd3),
    .decode_error(err3), .err_clear(clr3), .fifo_level(lvl3));

  base64_pixel_unpacker #(.PIXEL_W(4), .FIFO_DEPTH(8), .FRAME_PIXELS(2)) u4 (
    .clk(clk), .rst_n(r4_n), .rx_data(d4), .rx_data_valid(v4), .rx_data_ready(rdy4),
    .pixel_data(pd4), .pixel_valid(pv4), .pixel_ready(pr4), .frame_done(fd4),
    .decode_error(err4), .err_clear(clr4), .fifo_level(lvl4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send(input bit which4, input logic [7:0] c, input bit clr);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge clk); #1;
    if (which4) begin d4 = c; v4 = 1'b1; clr4 = clr; end
    else        begin d3 = c; v3 = 1'b1; clr3 = clr; end
    while (!done && n < 200) begin
      @(negedge clk);
      if ((which4 ? rdy4 : rdy3) === 1'b1) done = 1'b1;
      @(posedge clk);
      n++;
    end
    #1;
    v3 = 1'b0; clr3 = 1'b0; v4 = 1'b0; clr4 = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout char=%0d actual=not_accepted expected=accepted", c);
    end
  endtask

  task automatic drain(input bit which4);
    int n;
    n = 0;
    while (n < 300 && ((which4 ? q4.size() : q3.size()) != 0 || (which4 ? pv4 : pv3) !== 1'b0)) begin
      @(negedge clk);
      n++;
    end
    chk(which4 ? "drain4_left" : "drain3_left", which4 ? q4.size() : q3.size(), 0);
    chk(which4 ? "drain4_level" : "drain3_level", which4 ? 32'(lvl4) : 32'(lvl3), 0);
  endtask

  always @(negedge clk) begin
    chk("frame_done3", fd3, 0);
    if (pv3 === 1'b1 && pr3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pix3_extra actual=%0d expected=none", pd3);
      end else begin
        chk("pix3", pd3, q3.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    chk("frame_done4", fd4, fd_pend4);
    if (fd4 === 1'b1) fd4_cnt++;
    fd_pend4 = 1'b0;
    if (pv4 === 1'b1 && pr4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pix4_extra actual=%0d expected=none", pd4);
      end else begin
        chk("pix4", pd4, q4.pop_front());
      end
      pops4++;
      if (pops4 % 2 == 0) fd_pend4 = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    r3_n = 0; v3 = 0; d3 = 0; pr3 = 1; clr3 = 0;
    r4_n = 0; v4 = 0; d4 = 0; pr4 = 1; clr4 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy3, 0);
    chk("rst_valid", pv3, 0);
    chk("rst_data", pd3, 0);
    chk("rst_level", lvl3, 0);
    chk("rst_err", err3, 0);
    @(posedge clk); #1;
    r3_n = 1; r4_n = 1;
    @(negedge clk);
    chk("ready_after_rst3", rdy3, 1);
    chk("ready_after_rst4", rdy4, 1);

    // '/','w','B' at 3 bits per pixel
    q3.push_back(7); q3.push_back(7);
    send(0, "/", 0);
    @(negedge clk); chk("latency_c1", pv3, 0);
    @(negedge clk); chk("latency_c2", pv3, 1);
    q3.push_back(6); q3.push_back(0);
    send(0, "w", 0);
    q3.push_back(0); q3.push_back(1);
    send(0, "B", 0);
    drain(0);

    // padding drops residual bits
    q4.push_back(8);
    send(1, "g", 0);
    send(1, "=", 0);
    repeat (3) @(posedge clk);
    #1 pr4 = 0;
    q4.push_back(15);
    send(1, "/", 0);
    repeat (4) @(negedge clk);
    chk("pad_level", lvl4, 1);
    @(posedge clk); #1 pr4 = 1;
    drain(1);

    // frame wrap clears trailing sextet bits
    q4.push_back(15); q4.push_back(12); q4.push_back(15);
    send(1, "/", 0);
    send(1, "A", 0);
    send(1, "/", 0);
    drain(1);
    chk("frame_pulses", fd4_cnt, 2);

    // whitespace, invalid character and sticky error
    q3.push_back(0); q3.push_back(0);
    send(0, "A", 0);
    send(0, 8'h0D, 0);
    @(negedge clk); chk("err_ws", err3, 0);
    send(0, "#", 0);
    @(negedge clk); chk("err_set", err3, 1);
    q3.push_back(0); q3.push_back(0);
    send(0, "A", 0);
    @(negedge clk); chk("err_sticky", err3, 1);
    send(0, "#", 1);
    @(negedge clk); chk("err_clear_vs_new", err3, 1);
    @(posedge clk); #1 clr3 = 1;
    @(posedge clk); #1 clr3 = 0;
    @(negedge clk); chk("err_cleared", err3, 0);
    drain(0);

    // backpressure on the depth-4 FIFO
    pr3 = 0;
    repeat (8) q3.push_back(0);
    fork
      begin
        repeat (4) send(0, "A", 0);
      end
      begin
        n = 0;
        while (lvl3 !== 3'd4 && n < 100) begin @(negedge clk); n++; end
        chk("bp_level_full", lvl3, 4);
        repeat (3) @(negedge clk);
        chk("bp_level_hold", lvl3, 4);
        chk("bp_ready_low", rdy3, 0);
        @(posedge clk); #1 pr3 = 1;
      end
    join
    drain(0);

    // mid-stream reset with three pixels held
    pr3 = 0;
    send(0, "/", 0);
    send(0, "/", 0);
    n = 0;
    while (lvl3 !== 3'd3 && n < 100) begin @(negedge clk); n++; end
    chk("pre_rst_level", lvl3, 3);
    r3_n = 0;
    q3.delete();
    @(posedge clk); #1 r3_n = 1;
    @(negedge clk);
    chk("mid_rst_valid", pv3, 0);
    chk("mid_rst_level", lvl3, 0);
    chk("mid_rst_ready", rdy3, 1);
    pr3 = 1;
    q3.push_back(0); q3.push_back(1);
    send(0, "B", 0);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
